// File: rtl/console_ctrl_pkg.sv
// Shared constants and state encoding for the console output controller.
package console_ctrl_pkg;

    localparam int XLEN           = 32;
    localparam int CONSOLE_ST_LEN = 2;

    typedef enum logic [CONSOLE_ST_LEN-1:0] {
        CONSOLE_ST_RUN   = 2'd0,
        CONSOLE_ST_DRAIN = 2'd1,
        CONSOLE_ST_DONE  = 2'd2
    } console_st_e;

endpackage

// File: rtl/console_ctrl_fifo.sv
// Show-ahead character FIFO: storage, wrapping pointers and a separate
// occupancy counter so full and empty are unambiguous.
module console_ctrl_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointer and occupancy values from the push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards buffered data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Character storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));

endmodule

// File: rtl/console_ctrl.sv
// Console output controller: buffers core console writes, drains them over a
// valid/ready byte port with optional pacing, and sequences end-of-test so
// done/passed rise only after every buffered character has left.
module console_ctrl #(
    parameter int XLEN     = console_ctrl_pkg::XLEN,
    parameter int DEPTH    = 16,
    parameter int CHAR_GAP = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   console_we,
    input  logic [XLEN-1:0]        console_wdata,
    input  logic                   halt,
    input  logic                   passed_in,
    input  logic                   tx_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   done,
    output logic                   passed
);

    import console_ctrl_pkg::*;

    localparam int GAP_W = (CHAR_GAP > 0) ? $clog2(CHAR_GAP + 1) : 1;

    console_st_e      state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             overflow_q, overflow_d;
    logic             pass_lat_q, pass_lat_d;
    logic             done_q, done_d;
    logic             passed_q, passed_d;

    logic             push_s, pop_s, drop_s, tx_valid_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [7:0]       fifo_rdata_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
    logic             unused_wdata_s;

    // Only the low byte carries a character.
    assign unused_wdata_s = ^console_wdata[XLEN-1:8];

    console_ctrl_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .wdata   (console_wdata[7:0]),
        .rdata   (fifo_rdata_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Handshake decode: a full FIFO still takes a write when it pops the same cycle.
    always_comb begin
        tx_valid_s = !fifo_empty_s && (gap_q == GAP_W'(0)) && (state_q != CONSOLE_ST_DONE);
        pop_s      = tx_valid_s && tx_ready;
        push_s     = console_we && (state_q != CONSOLE_ST_DONE) && (!fifo_full_s || pop_s);
        drop_s     = console_we && (state_q != CONSOLE_ST_DONE) && fifo_full_s && !pop_s;
    end

    // Pacing counter, sticky overflow and the run/drain/done sequencer.
    always_comb begin
        gap_d      = gap_q;
        overflow_d = overflow_q | drop_s;
        pass_lat_d = pass_lat_q;
        state_d    = state_q;

        if (pop_s) begin
            gap_d = GAP_W'(CHAR_GAP);
        end else if (gap_q != GAP_W'(0)) begin
            gap_d = gap_q - GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end

        case (state_q)
            CONSOLE_ST_RUN: begin
                if (halt) begin
                    state_d    = CONSOLE_ST_DRAIN;
                    pass_lat_d = passed_in;
                end else begin
                    state_d = CONSOLE_ST_RUN;
                end
            end
            CONSOLE_ST_DRAIN: begin
                if (fifo_empty_s && (gap_q == GAP_W'(0)) && !push_s) begin
                    state_d = CONSOLE_ST_DONE;
                end else begin
                    state_d = CONSOLE_ST_DRAIN;
                end
            end
            CONSOLE_ST_DONE: begin
                state_d = CONSOLE_ST_DONE;
            end
            default: begin
                state_d = CONSOLE_ST_RUN;
            end
        endcase

        // done/passed are registered from the next state so they rise with DONE.
        done_d   = (state_d == CONSOLE_ST_DONE);
        passed_d = (state_d == CONSOLE_ST_DONE) && pass_lat_d && !overflow_d;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CONSOLE_ST_RUN;
            gap_q      <= '0;
            overflow_q <= 1'b0;
            pass_lat_q <= 1'b0;
            done_q     <= 1'b0;
            passed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            overflow_q <= overflow_d;
            pass_lat_q <= pass_lat_d;
            done_q     <= done_d;
            passed_q   <= passed_d;
        end
    end

    assign tx_valid   = tx_valid_s;
    assign tx_data    = fifo_rdata_s;
    assign fifo_count = fifo_count_s;
    assign overflow   = overflow_q;
    assign done       = done_q;
    assign passed     = passed_q;

endmodule

// File: tb/tb_console_ctrl.sv
// Directed self-checking bench for console_ctrl: one instance back-to-back,
// one instance with CHAR_GAP=3 for pacing.
module tb_console_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        we0 = 1'b0, halt0 = 1'b0, pin0 = 1'b0, rdy0 = 1'b0;
    logic [31:0] wd0 = 32'h0;
    logic        val0, ovf0, done0, pass0;
    logic [7:0]  txd0;
    logic [4:0]  cnt0;

    logic        we1 = 1'b0, halt1 = 1'b0, pin1 = 1'b0, rdy1 = 1'b0;
    logic [31:0] wd1 = 32'h0;
    logic        val1, ovf1, done1, pass1;
    logic [7:0]  txd1;
    logic [4:0]  cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    console_ctrl #(.XLEN(32), .DEPTH(16), .CHAR_GAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .console_we(we0), .console_wdata(wd0),
        .halt(halt0), .passed_in(pin0), .tx_ready(rdy0), .tx_valid(val0),
        .tx_data(txd0), .fifo_count(cnt0), .overflow(ovf0), .done(done0),
        .passed(pass0)
    );

    console_ctrl #(.XLEN(32), .DEPTH(16), .CHAR_GAP(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .console_we(we1), .console_wdata(wd1),
        .halt(halt1), .passed_in(pin1), .tx_ready(rdy1), .tx_valid(val1),
        .tx_data(txd1), .fifo_count(cnt1), .overflow(ovf1), .done(done1),
        .passed(pass1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        we0 = 1'b0; halt0 = 1'b0; pin0 = 1'b0; rdy0 = 1'b0; wd0 = 32'h0;
        we1 = 1'b0; halt1 = 1'b0; pin1 = 1'b0; rdy1 = 1'b0; wd1 = 32'h0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_valid", {31'h0, val0}, 32'h0);
        chk("rst_count", {27'h0, cnt0}, 32'h0);
        chk("rst_ovf", {31'h0, ovf0}, 32'h0);
        chk("rst_done", {31'h0, done0}, 32'h0);
        chk("rst_passed", {31'h0, pass0}, 32'h0);
        do_reset();

        // 1: "Hi" back-to-back, upper data bits ignored
        rdy0 = 1'b1;
        we0 = 1'b1; wd0 = 32'hAABB_CC48;
        tick();
        chk("t1_valid_h", {31'h0, val0}, 32'h1);
        chk("t1_data_h", {24'h0, txd0}, 32'h48);
        chk("t1_cnt_h", {27'h0, cnt0}, 32'h1);
        wd0 = 32'h1234_5669;
        tick();
        we0 = 1'b0;
        chk("t1_valid_i", {31'h0, val0}, 32'h1);
        chk("t1_data_i", {24'h0, txd0}, 32'h69);
        chk("t1_cnt_i", {27'h0, cnt0}, 32'h1);
        tick();
        chk("t1_valid_end", {31'h0, val0}, 32'h0);
        chk("t1_cnt_end", {27'h0, cnt0}, 32'h0);

        // 2: 17 writes into 16 entries with the sink stalled
        rdy0 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            we0 = 1'b1; wd0 = 32'h41 + 32'(i);
            tick();
        end
        we0 = 1'b0;
        chk("t2_cnt_full", {27'h0, cnt0}, 32'd16);
        chk("t2_ovf", {31'h0, ovf0}, 32'h1);
        chk("t2_hold", {24'h0, txd0}, 32'h41);
        tick();
        chk("t2_hold2", {24'h0, txd0}, 32'h41);
        rdy0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain_valid", {31'h0, val0}, 32'h1);
            chk("t2_drain_data", {24'h0, txd0}, 32'h41 + 32'(i));
            tick();
        end
        chk("t2_cnt_end", {27'h0, cnt0}, 32'h0);
        chk("t2_valid_end", {31'h0, val0}, 32'h0);
        chk("t2_ovf_sticky", {31'h0, ovf0}, 32'h1);

        // 3: pacing with CHAR_GAP=3 on the second instance
        do_reset();
        for (int i = 0; i < 3; i++) begin
            we1 = 1'b1; wd1 = 32'h31 + 32'(i);
            tick();
        end
        we1 = 1'b0;
        chk("t3_cnt_pre", {27'h0, cnt1}, 32'd3);
        rdy1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_pulse", {31'h0, val1}, 32'h1);
            chk("t3_data", {24'h0, txd1}, 32'h31 + 32'(k));
            chk("t3_cnt", {27'h0, cnt1}, 32'd3 - 32'(k));
            tick();
            for (int j = 0; j < 3; j++) begin
                chk("t3_gap_idle", {31'h0, val1}, 32'h0);
                chk("t3_gap_cnt", {27'h0, cnt1}, 32'd2 - 32'(k));
                tick();
            end
        end
        chk("t3_cnt_end", {27'h0, cnt1}, 32'h0);
        chk("t3_valid_end", {31'h0, val1}, 32'h0);
        rdy1 = 1'b0;

        // 4: full FIFO, push and pop in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) begin
            we0 = 1'b1; wd0 = 32'h30 + 32'(i);
            tick();
        end
        we0 = 1'b0;
        chk("t4_cnt_full", {27'h0, cnt0}, 32'd16);
        rdy0 = 1'b1; we0 = 1'b1; wd0 = 32'h5A;
        tick();
        we0 = 1'b0; rdy0 = 1'b0;
        chk("t4_cnt_same", {27'h0, cnt0}, 32'd16);
        chk("t4_ovf_clear", {31'h0, ovf0}, 32'h0);
        chk("t4_head", {24'h0, txd0}, 32'h31);
        rdy0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_drain_data", {24'h0, txd0}, (i == 15) ? 32'h5A : 32'h31 + 32'(i));
            tick();
        end
        chk("t4_cnt_end", {27'h0, cnt0}, 32'h0);

        // 5: halt with 5 buffered characters, drain then done/passed
        do_reset();
        for (int i = 0; i < 5; i++) begin
            we0 = 1'b1; wd0 = 32'h61 + 32'(i);
            tick();
        end
        we0 = 1'b0;
        halt0 = 1'b1; pin0 = 1'b1;
        tick();
        halt0 = 1'b0; pin0 = 1'b0;
        chk("t5_done_wait", {31'h0, done0}, 32'h0);
        tick();
        chk("t5_done_wait2", {31'h0, done0}, 32'h0);
        rdy0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_drain_done", {31'h0, done0}, 32'h0);
            chk("t5_drain_data", {24'h0, txd0}, 32'h61 + 32'(i));
            tick();
        end
        chk("t5_done_late", {31'h0, done0}, 32'h0);
        tick();
        chk("t5_done", {31'h0, done0}, 32'h1);
        chk("t5_passed", {31'h0, pass0}, 32'h1);
        we0 = 1'b1; wd0 = 32'h7A;
        tick();
        we0 = 1'b0;
        chk("t5_ignored_cnt", {27'h0, cnt0}, 32'h0);
        chk("t5_ignored_valid", {31'h0, val0}, 32'h0);
        chk("t5_ignored_ovf", {31'h0, ovf0}, 32'h0);
        chk("t5_done_stays", {31'h0, done0}, 32'h1);

        // 6: asynchronous reset mid-drain
        do_reset();
        for (int i = 0; i < 8; i++) begin
            we0 = 1'b1; wd0 = 32'h70 + 32'(i);
            tick();
        end
        we0 = 1'b0;
        chk("t6_cnt_pre", {27'h0, cnt0}, 32'd8);
        halt0 = 1'b1; pin0 = 1'b1;
        tick();
        halt0 = 1'b0; pin0 = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'h0, val0}, 32'h0);
        chk("t6_async_cnt", {27'h0, cnt0}, 32'h0);
        chk("t6_async_done", {31'h0, done0}, 32'h0);
        chk("t6_async_passed", {31'h0, pass0}, 32'h0);
        chk("t6_async_ovf", {31'h0, ovf0}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        we0 = 1'b1; wd0 = 32'h51;
        tick();
        we0 = 1'b0;
        chk("t6_run_cnt", {27'h0, cnt0}, 32'h1);
        rdy0 = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_run_cnt_end", {27'h0, cnt0}, 32'h0);
        chk("t6_run_not_done", {31'h0, done0}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
